// File: rtl/tt_counter_core.sv
// tt_counter_core: prescaled up/down counter with modulo limit, wrap/saturate, load, tc and compare match
module tt_counter_core #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               up,
    input  logic               mode,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   limit,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   cmp_val,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               match,
    output logic               tick
);
    logic [PRESC_W-1:0] pdiv_q, pdiv_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               tc_q, tc_d, tick_q, tick_d, match_q;
    logic               step;

    // next-state: load beats step beats hold; tc flags wraps and fresh arrivals at a saturate boundary
    always_comb begin
        step    = en && (pdiv_q == presc);
        pdiv_d  = en ? (step ? '0 : pdiv_q + PRESC_W'(1)) : pdiv_q;
        count_d = count_q;
        tc_d    = 1'b0;
        tick_d  = 1'b0;
        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
            pdiv_d  = '0;
        end else if (step) begin
            tick_d = 1'b1;
            if (up) begin
                count_d = (count_q < limit) ? count_q + WIDTH'(1) : (mode ? limit : '0);
                tc_d    = (count_q < limit) ? (mode && count_d == limit) : (!mode || count_q != limit);
            end else begin
                count_d = (count_q > limit) ? limit :
                          (count_q != '0)   ? count_q - WIDTH'(1) : (mode ? '0 : limit);
                tc_d    = (count_q > limit) ? 1'b0 :
                          (count_q != '0)   ? (mode && count_q == WIDTH'(1)) : !mode;
            end
        end
    end

    // state registers; match is computed from the next count so it lines up with count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdiv_q  <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
            tick_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            pdiv_q  <= pdiv_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            tick_q  <= tick_d;
            match_q <= (count_d == cmp_val);
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign tick  = tick_q;
    assign match = match_q;
endmodule

// File: tb/tb_tt_counter_core.sv
// tb_tt_counter_core: directed self-checking bench for tt_counter_core
module tb_tt_counter_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b1, mode = 1'b0, load = 1'b0;
    logic [7:0] load_val = '0, limit = 8'hFF, cmp_val = 8'hAA;
    logic [3:0] presc = '0;
    logic [7:0] count;
    logic       tc, match, tick;
    int         n_checks = 0, n_errors = 0;

    tt_counter_core #(.WIDTH(8), .PRESC_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .load(load),
        .load_val(load_val), .limit(limit), .presc(presc), .cmp_val(cmp_val),
        .count(count), .tc(tc), .match(match), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic chk3(input string tag, input logic [31:0] c, input logic [31:0] t, input logic [31:0] k);
        check({tag, "_count"}, 32'(count), c);
        check({tag, "_tc"}, 32'(tc), t);
        check({tag, "_tick"}, 32'(tick), k);
    endtask

    initial begin
        cyc();
        cyc();
        rst = 1'b0;
        do_load(8'h37);
        check("pre_reset_count", 32'(count), 32'h37);
        #2 rst = 1'b1;
        #1;
        chk3("async_reset", 0, 0, 0);
        check("async_reset_match", 32'(match), 0);
        cmp_val = 8'h03;
        en = 1'b1;
        up = 1'b1;
        presc = 4'd0;
        cyc();
        rst = 1'b0;
        cyc();
        chk3("post_rst1", 1, 0, 1);
        check("post_rst1_match", 32'(match), 0);
        cyc();
        chk3("post_rst2", 2, 0, 1);
        cyc();
        chk3("post_rst3", 3, 0, 1);
        check("post_rst3_match", 32'(match), 1);

        presc = 4'd3;
        do_load(8'h00);
        check("presc_load", 32'(count), 0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk3($sformatf("presc_e%0d", i), 32'(i / 4), 0, (i % 4 == 0) ? 1 : 0);
        end
        cyc();
        cyc();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk3($sformatf("freeze%0d", i), 2, 0, 0);
        end
        en = 1'b1;
        cyc();
        chk3("resume1", 2, 0, 0);
        cyc();
        chk3("resume2", 3, 0, 1);

        presc = 4'd0;
        limit = 8'd9;
        mode = 1'b0;
        do_load(8'd7);
        cyc();
        chk3("wrap8", 8, 0, 1);
        cyc();
        chk3("wrap9", 9, 0, 1);
        cyc();
        chk3("wrap0", 0, 1, 1);
        up = 1'b0;
        cyc();
        chk3("wrap_down9", 9, 1, 1);
        cyc();
        chk3("wrap_down8", 8, 0, 1);

        mode = 1'b1;
        limit = 8'd5;
        up = 1'b1;
        do_load(8'd3);
        chk3("sat_load", 3, 0, 0);
        cyc();
        chk3("sat4", 4, 0, 1);
        cyc();
        chk3("sat5a", 5, 1, 1);
        cyc();
        chk3("sat5b", 5, 0, 1);
        cyc();
        chk3("sat5c", 5, 0, 1);
        up = 1'b0;
        do_load(8'd1);
        cyc();
        chk3("sat_dn0a", 0, 1, 1);
        cyc();
        chk3("sat_dn0b", 0, 0, 1);

        en = 1'b0;
        mode = 1'b0;
        up = 1'b1;
        limit = 8'hFF;
        cmp_val = 8'h20;
        do_load(8'h20);
        check("cmp_load_count", 32'(count), 32'h20);
        check("cmp_load_match", 32'(match), 1);
        cmp_val = 8'h21;
        en = 1'b1;
        cyc();
        check("cmp_step_count", 32'(count), 32'h21);
        check("cmp_step_match", 32'(match), 1);
        do_load(8'h10);
        chk3("load_wins", 32'h10, 0, 0);
        check("load_wins_match", 32'(match), 0);
        en = 1'b0;
        limit = 8'h80;
        do_load(8'hF0);
        check("load_clamp", 32'(count), 32'h80);

        limit = 8'hFF;
        do_load(8'd50);
        limit = 8'd10;
        up = 1'b0;
        en = 1'b1;
        cyc();
        chk3("lim_down_clamp", 10, 0, 1);
        en = 1'b0;
        limit = 8'hFF;
        do_load(8'd50);
        limit = 8'd10;
        up = 1'b1;
        en = 1'b1;
        cyc();
        chk3("lim_up_wrap", 0, 1, 1);

        limit = 8'd0;
        mode = 1'b0;
        cyc();
        chk3("lim0_wrap", 0, 1, 1);
        mode = 1'b1;
        cyc();
        chk3("lim0_sat", 0, 0, 1);
        en = 1'b0;
        cyc();
        chk3("en_low_clear", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
